// File: rtl/nand_equiv_checker.sv
// nand_equiv_checker: walks vec_o through every N-bit input combination,
// lets two external single-output implementations settle, and compares their
// results. It keeps a mismatch count, the first failing vector and a pass flag.
module nand_equiv_checker #(
  parameter int N      = 2,
  parameter int SETTLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         res_a,
  input  logic         res_b,
  output logic [N-1:0] vec_o,
  output logic         busy,
  output logic         done,
  output logic         pass,
  output logic [N:0]   fail_count,
  output logic [N-1:0] first_fail_vec,
  output logic         fail_valid
);

  typedef enum logic [1:0] {IDLE, SETTLE_S, CHECK, DONE_S} state_t;

  // Wide enough to hold SETTLE-1; never narrower than one bit.
  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(SETTLE - 1);
  localparam logic [N-1:0]  LAST_VEC = '1;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          mismatch;
  logic [N:0]    fc_next;

  assign mismatch = res_a ^ res_b;
  // Count including the vector being checked now, so pass can be decided
  // on the same edge that enters DONE.
  assign fc_next  = fail_count + {{N{1'b0}}, mismatch};

  // Sweep sequencer with all outputs registered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      cnt            <= '0;
      vec_o          <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      fail_count     <= '0;
      first_fail_vec <= '0;
      fail_valid     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            vec_o          <= '0;
            fail_count     <= '0;
            fail_valid     <= 1'b0;
            first_fail_vec <= '0;
            pass           <= 1'b0;
            cnt            <= CNT_INIT;
            busy           <= 1'b1;
            state          <= SETTLE_S;
          end
        end
        SETTLE_S: begin
          if (cnt == '0) state <= CHECK;
          else           cnt   <= cnt - 1'b1;
        end
        CHECK: begin
          fail_count <= fc_next;
          if (mismatch && !fail_valid) begin
            first_fail_vec <= vec_o;
            fail_valid     <= 1'b1;
          end
          if (vec_o == LAST_VEC) begin
            done  <= 1'b1;
            pass  <= (fc_next == '0);
            state <= DONE_S;
          end else begin
            vec_o <= vec_o + 1'b1;
            cnt   <= CNT_INIT;
            state <= SETTLE_S;
          end
        end
        DONE_S: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nand_equiv_checker.sv
// Bench for nand_equiv_checker: two instances (N=2/SETTLE=1 and N=3/SETTLE=3)
// whose external implementations are truth tables indexed by vec_o.
module tb_nand_equiv_checker;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] st = '0;
  logic [7:0] tta = '0, ttb = '0;
  int cyc = 0;
  int tests = 0, fails = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // instance 0: N=2, SETTLE=1
  logic [1:0] vec0, ffv0;
  logic [2:0] fc0;
  logic busy0, done0, pass0, fv0, ra0, rb0;
  assign ra0 = tta[vec0];
  assign rb0 = ttb[vec0];

  nand_equiv_checker #(.N(2), .SETTLE(1)) u0 (
    .clk(clk), .rst_n(rst_n), .start(st[0]), .res_a(ra0), .res_b(rb0),
    .vec_o(vec0), .busy(busy0), .done(done0), .pass(pass0),
    .fail_count(fc0), .first_fail_vec(ffv0), .fail_valid(fv0));

  // instance 1: N=3, SETTLE=3
  logic [2:0] vec1, ffv1;
  logic [3:0] fc1;
  logic busy1, done1, pass1, fv1, ra1, rb1;
  assign ra1 = tta[vec1];
  assign rb1 = ttb[vec1];

  nand_equiv_checker #(.N(3), .SETTLE(3)) u1 (
    .clk(clk), .rst_n(rst_n), .start(st[1]), .res_a(ra1), .res_b(rb1),
    .vec_o(vec1), .busy(busy1), .done(done1), .pass(pass1),
    .fail_count(fc1), .first_fail_vec(ffv1), .fail_valid(fv1));

  // selected-instance view
  bit sel;
  logic [2:0] s_vec, s_ffv;
  logic [3:0] s_fc;
  logic s_busy, s_done, s_pass, s_fv;
  always_comb begin
    s_vec = {1'b0, vec0}; s_ffv = {1'b0, ffv0}; s_fc = {1'b0, fc0};
    s_busy = busy0; s_done = done0; s_pass = pass0; s_fv = fv0;
    if (sel) begin
      s_vec = vec1; s_ffv = ffv1; s_fc = fc1;
      s_busy = busy1; s_done = done1; s_pass = pass1; s_fv = fv1;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: mismatch statistics straight from the two truth tables.
  task automatic model(input bit s, input logic [7:0] a, input logic [7:0] b,
                       output int efc, output int effv, output bit efv, output bit epass);
    int nv;
    nv = s ? 8 : 4;
    efc = 0; effv = 0; efv = 0;
    for (int v = 0; v < nv; v++)
      if (a[v] != b[v]) begin
        if (!efv) effv = v;
        efv = 1;
        efc++;
      end
    epass = (efc == 0);
  endtask

  // One complete sweep on the selected instance with timing/sequence checks.
  task automatic run(input bit s, input logic [7:0] a, input logic [7:0] b, input bit hold,
                     input int efc, input int effv, input bit efv, input bit epass);
    int k, dn, dat, sp, nv, t;
    bit vbad, bbad, after_busy;
    sel = s;
    sp = s ? 4 : 2;
    nv = s ? 8 : 4;
    tta = a; ttb = b;
    @(negedge clk);
    st[s] = 1'b1;
    k = cyc + 1;
    dn = 0; dat = -1; vbad = 0; bbad = 0; after_busy = 0;
    for (int i = 0; i < 200 && dat < 0; i++) begin
      @(negedge clk);
      if (!hold) st[s] = 1'b0;
      t = cyc - k;
      if (t < nv * sp && int'(s_vec) != t / sp) vbad = 1;
      if (!s_busy) bbad = 1;
      if (s_done) begin dn++; dat = t; end
    end
    st[s] = 1'b0;
    chk("done_at", dat, nv * sp);
    chk("busy_during", bbad, 0);
    chk("vec_sequence", vbad, 0);
    chk("fail_count", s_fc, efc);
    chk("fail_valid", s_fv, efv);
    if (efv) chk("first_fail_vec", s_ffv, effv);
    chk("pass_at_done", s_pass, epass);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (s_done) dn++;
      if (s_busy) after_busy = 1;
    end
    chk("done_pulses", dn, 1);
    chk("idle_busy", after_busy, 0);
    chk("pass_held", s_pass, epass);
  endtask

  typedef struct {
    bit s; logic [7:0] a; logic [7:0] b; bit hold;
    int efc; int effv; bit efv; bit epass;
  } vec_t;
  vec_t tbl[6];

  initial begin
    int efc, effv, wt;
    bit efv, epass;
    logic [7:0] ra, rb;
    bit rs;
    // bit index of each table = vec_o value; vec_o[1]=a, vec_o[0]=b
    tbl[0] = '{0, 8'h07, 8'h07, 0, 0, 0, 0, 1}; // NAND vs ~a|~b
    tbl[1] = '{0, 8'h0E, 8'h07, 0, 2, 0, 1, 0}; // a|b vs ~(a&b)
    tbl[2] = '{0, 8'h06, 8'h06, 1, 0, 0, 0, 1}; // start held through sweep
    tbl[3] = '{1, 8'h96, 8'h69, 0, 8, 0, 1, 0}; // inverted
    tbl[4] = '{1, 8'hE8, 8'hE8, 0, 0, 0, 0, 1}; // equal
    tbl[5] = '{0, 8'h00, 8'h08, 0, 1, 3, 1, 0}; // only last vector differs

    sel = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst0_out", {vec0, busy0, done0, pass0, fc0, ffv0, fv0}, 0);
    chk("rst1_out", {vec1, busy1, done1, pass1, fc1, ffv1, fv1}, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++)
      run(tbl[i].s, tbl[i].a, tbl[i].b, tbl[i].hold,
          tbl[i].efc, tbl[i].effv, tbl[i].efv, tbl[i].epass);

    // mid-sweep reset at vec_o=10 with a mismatch already recorded
    sel = 0; tta = 8'h0E; ttb = 8'h07;
    @(negedge clk); st[0] = 1'b1;
    @(negedge clk); st[0] = 1'b0;
    wt = 0;
    while (vec0 != 2'b10 && wt < 50) begin @(negedge clk); wt++; end
    chk("reach_vec10", wt < 50, 1);
    chk("pre_rst_fc", fc0, 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst_out", {vec0, busy0, done0, pass0, fc0, ffv0, fv0}, 0);
    wt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done0 || busy0) wt++;
    end
    chk("midrst_quiet", wt, 0);
    run(tbl[0].s, tbl[0].a, tbl[0].b, 0, 0, 0, 0, 1);

    // randomized truth tables against the reference model
    for (int i = 0; i < 8; i++) begin
      rs = i[0];
      ra = 8'($urandom);
      rb = ($urandom_range(0, 2) == 0) ? ra : 8'($urandom);
      model(rs, ra, rb, efc, effv, efv, epass);
      run(rs, ra, rb, 0, efc, effv, efv, epass);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/nand_equiv_checker.md
# nand_equiv_checker

- Self-running equivalence checker for two single-output combinational implementations of the same N-input function, e.g. a NAND-only realisation versus an expression realisation.
- Sweeps vec_o through every input combination in ascending order, waits a settle interval, and compares the two returned results.
- Reports the mismatch count, the first failing vector and a pass flag.
- It is the consuming/checking end of the truth-table stimulus flow, so lab gate exercises can be verified in hardware instead of by reading a monitor printout.

## Interface
- N, default 2: number of function inputs; supported range 1..8.
- SETTLE, default 1: cycles vec_o is held before comparison; must be ≥ 1.
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous reset, active-low (sampled on clk rising edge).
- start  input  1  begin a sweep; accepted only in IDLE.
- res_a  input  1  output of implementation A for vec_o.
- res_b  input  1  output of implementation B for vec_o.
- vec_o  output  N  input vector driven to both implementations; vec_o[N-1] is the first (leftmost, x) input, vec_o[0] the last (y).
- busy  output  1  high from start acceptance until DONE is left.
- done  output  1  one-cycle pulse at the end of a sweep.
- pass  output  1  high after a completed sweep with zero mismatches; held until the next accepted start or reset.
- fail_count  output  N+1  mismatches in the last or current sweep; max 2^N, no saturation needed.
- first_fail_vec  output  N  vec_o value of the first mismatch; valid when fail_valid is high.
- fail_valid  output  1  at least one mismatch seen in the current/last sweep.

## Operation
- Reset (rst_n low at an edge): state IDLE; vec_o=0, busy=0, done=0, pass=0, fail_count=0, first_fail_vec=0, fail_valid=0. Reset has priority over all other events, including mid-sweep; the sweep is abandoned and no done pulse is produced.
- IDLE, start=1: vec_o←0, fail_count←0, fail_valid←0, first_fail_vec←0, pass←0, settle counter←SETTLE-1, busy←1, go to SETTLE.
- IDLE, start=0: hold all outputs (pass and results stay visible).
- SETTLE: if counter=0, go to CHECK; else decrement. vec_o is held.
- CHECK: mismatch = (res_a != res_b), sampled at this edge.
  - On mismatch: fail_count+1. If fail_valid=0: first_fail_vec←vec_o and fail_valid←1.
  - If vec_o = 2^N-1: go to DONE, vec_o unchanged. Otherwise vec_o+1, counter←SETTLE-1, go to SETTLE.
- DONE: done=1, busy=1 for this one cycle; pass←(fail_count==0), using the count including the last CHECK. Next edge: IDLE, done←0, busy←0.
- start while busy (SETTLE/CHECK/DONE) is ignored; no restart, no queueing.
- Results registers change only in CHECK and on start acceptance.

## Timing
- All outputs are registered; no combinational path from inputs to outputs.
- start accepted at edge k: each vector v (0..2^N-1) is driven from edge k+v(SETTLE+1), and res_a/res_b are sampled at edge k+(v+1)(SETTLE+1).
- DONE is entered at edge k+2^N(SETTLE+1); done and pass are visible for that cycle, and IDLE follows one edge later.
- Sweep length: 2^N(SETTLE+1)+1 cycles of busy. N=2, SETTLE=1: busy for 9 cycles.
- The external implementations must settle within SETTLE cycles of the vec_o change.

## Test plan
- N=2, SETTLE=1; res_a = NAND-only ~a|~b, res_b = expression ~a|~b. Pulse start → vec_o steps 00,01,10,11; done pulses 8 edges after acceptance; pass=1, fail_count=0, fail_valid=0.
- Same setup with res_a = a|b, res_b = ~(a&b) → mismatches at 00 and 11; fail_count=2, first_fail_vec=00, fail_valid=1, pass=0.
- Hold start high for the whole sweep, plus an extra pulse in the DONE cycle → exactly one sweep; done pulses once; IDLE with busy=0 afterwards.
- Drive rst_n low for one edge while vec_o=10 → next cycle all outputs are 0 and state is IDLE; no done pulse; a new start runs a full clean sweep.
- SETTLE=3, res_b = res_a inverted → vec_o changes every 4 cycles; done at edge k+16; fail_count=4 (100b), first_fail_vec=00.
- N=3, SETTLE=1, outputs forced equal → 8 vectors 000..111 in order; done at edge k+16; pass=1.
